// File: rtl/hex_defs.sv
// Shared definitions for the Intel-HEX record parser: record type codes and
// the parser state encoding.
package hex_defs;

  localparam logic [7:0] REC_DATA = 8'h00;
  localparam logic [7:0] REC_EOF  = 8'h01;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_ADDR_HI = 3'd2;
  localparam logic [2:0] ST_ADDR_LO = 3'd3;
  localparam logic [2:0] ST_TYPE    = 3'd4;
  localparam logic [2:0] ST_DATA    = 3'd5;
  localparam logic [2:0] ST_CSUM    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_LEN     = ST_LEN,
    S_ADDR_HI = ST_ADDR_HI,
    S_ADDR_LO = ST_ADDR_LO,
    S_TYPE    = ST_TYPE,
    S_DATA    = ST_DATA,
    S_CSUM    = ST_CSUM
  } state_t;

endpackage

// File: rtl/hex_byte_asm.sv
// Pairs successive hex digits into bytes. byte_done pulses combinationally
// with the second digit of a pair; clear forces the next digit to be a high nibble.
module hex_byte_asm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clear,
  input  logic [3:0] digit,
  output logic [7:0] byte_val,
  output logic       byte_done
);

  logic       phase_lo;
  logic [3:0] hi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_lo <= 1'b0;
      hi       <= 4'h0;
    end else if (clear) begin
      phase_lo <= 1'b0;
    end else if (load) begin
      if (!phase_lo) hi <= digit;
      phase_lo <= ~phase_lo;
    end
  end

  assign byte_val  = {hi, digit};
  assign byte_done = load & phase_lo;

endmodule

// File: rtl/hex_record_parser.sv
// Intel-HEX record parser: walks ":LL AAAA TT <data> CC", emits type-00 data
// bytes with absolute addresses, checks the checksum, flags format errors and EOF.
module hex_record_parser
  import hex_defs::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CHAR_VALID,
  input  logic              SC,
  input  logic              ISHEX,
  input  logic [3:0]        DIGIT,
  output logic [7:0]        DATA,
  output logic [ADDR_W-1:0] ADDR,
  output logic              DATA_VALID,
  output logic              REC_DONE,
  output logic              CSUM_ERR,
  output logic              FMT_ERR,
  output logic              EOF,
  output logic              BUSY
);

  state_t      state, state_next;
  logic [7:0]  len_cnt, rec_type, sum, sum_plus, byte_val;
  logic [15:0] base, idx, offset;
  logic        byte_done, load, clear;
  logic        emit, done_next, csum_bad, fmt_next, eof_set;

  assign load     = CHAR_VALID & ISHEX & ~SC & (state != S_IDLE);
  assign clear    = (state_next != state) | (CHAR_VALID & SC);
  assign sum_plus = sum + byte_val;
  assign offset   = base + idx;

  hex_byte_asm u_byte_asm (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (load),
    .clear    (clear),
    .digit    (DIGIT),
    .byte_val (byte_val),
    .byte_done(byte_done)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    fmt_next   = 1'b0;
    emit       = 1'b0;
    done_next  = 1'b0;
    csum_bad   = 1'b0;
    eof_set    = 1'b0;
    if (CHAR_VALID) begin
      if (SC) begin
        // A ':' always opens a new record; mid-record it also aborts the old one.
        state_next = S_LEN;
        fmt_next   = (state != S_IDLE);
      end else if (state != S_IDLE && !ISHEX) begin
        fmt_next   = 1'b1;
        state_next = S_IDLE;
      end else if (byte_done) begin
        case (state)
          S_LEN:     state_next = S_ADDR_HI;
          S_ADDR_HI: state_next = S_ADDR_LO;
          S_ADDR_LO: state_next = S_TYPE;
          S_TYPE:    state_next = (len_cnt == 8'd0) ? S_CSUM : S_DATA;
          S_DATA: begin
            emit = (rec_type == REC_DATA);
            if (len_cnt == 8'd1) state_next = S_CSUM;
          end
          S_CSUM: begin
            done_next  = 1'b1;
            csum_bad   = (sum_plus != 8'h00);
            eof_set    = (rec_type == REC_EOF) && (sum_plus == 8'h00);
            state_next = S_IDLE;
          end
          default: state_next = state;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      len_cnt    <= 8'h00;
      rec_type   <= 8'h00;
      sum        <= 8'h00;
      base       <= 16'h0000;
      idx        <= 16'h0000;
      DATA       <= 8'h00;
      ADDR       <= '0;
      DATA_VALID <= 1'b0;
      REC_DONE   <= 1'b0;
      CSUM_ERR   <= 1'b0;
      FMT_ERR    <= 1'b0;
      EOF        <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      DATA_VALID <= emit;
      REC_DONE   <= done_next;
      CSUM_ERR   <= csum_bad;
      FMT_ERR    <= fmt_next;
      BUSY       <= (state_next != S_IDLE);
      if (eof_set) EOF <= 1'b1;

      if (CHAR_VALID && SC) sum <= 8'h00;
      else if (byte_done)   sum <= sum_plus;

      if (byte_done) begin
        case (state)
          S_LEN:     len_cnt <= byte_val;
          S_ADDR_HI: base[15:8] <= byte_val;
          S_ADDR_LO: base[7:0] <= byte_val;
          S_TYPE: begin
            rec_type <= byte_val;
            idx      <= 16'h0000;
          end
          S_DATA: begin
            len_cnt <= len_cnt - 8'd1;
            idx     <= idx + 16'd1;
          end
          default: ;
        endcase
      end

      // Offset wraps inside 16 bits before being widened to the output.
      if (emit) begin
        DATA <= byte_val;
        ADDR <= ADDR_W'(offset);
      end
    end
  end

endmodule
